// File: rtl/rv_pkg.sv
// Shared RV32IM definitions for the execute stage: funct3 encodings, divider
// state, the EX/MEM pipeline-register layout and small arithmetic helpers.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs2;
        logic [31:0] eresult;
        logic [31:0] addr;
        logic [31:0] pc_correction;
        logic        nop;
        logic        is_load;
        logic        is_store;
        logic        is_csr;
        logic        correct_pc;
        logic        wb_enable;
        logic [4:0]  rd_id;
        logic [4:0]  rs1_id;
        logic [4:0]  rs2_id;
        logic [11:0] csr_id;
        logic [2:0]  funct3;
    } em_t;

    // Bubble: the only non-zero field is the nop marker.
    localparam em_t EM_BUBBLE = '{
        pc: 32'd0, instr: 32'd0, rs2: 32'd0, eresult: 32'd0, addr: 32'd0,
        pc_correction: 32'd0, nop: 1'b1, is_load: 1'b0, is_store: 1'b0,
        is_csr: 1'b0, correct_pc: 1'b0, wb_enable: 1'b0, rd_id: 5'd0,
        rs1_id: 5'd0, rs2_id: 5'd0, csr_id: 12'd0, funct3: 3'd0
    };

    function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] value);
        return neg ? (32'd0 - value) : value;
    endfunction

endpackage

// File: rtl/execute_unit_if.sv
// Decode-to-Execute operand bundle and the EX/MEM pipeline register outputs.
interface execute_unit_if;
    logic [31:0] DE_PC_i;
    logic [31:0] DE_instr_i;
    logic        DE_nop_i;
    logic        DE_isALUreg_i;
    logic        DE_isALUimm_i;
    logic        DE_isBranch_i;
    logic        DE_isJAL_i;
    logic        DE_isJALR_i;
    logic        DE_isLUI_i;
    logic        DE_isAUIPC_i;
    logic        DE_isLoad_i;
    logic        DE_isStore_i;
    logic        DE_isCSR_i;
    logic        DE_isMulDiv_i;
    logic [4:0]  DE_rdId_i;
    logic [4:0]  DE_rs1Id_i;
    logic [4:0]  DE_rs2Id_i;
    logic [11:0] DE_csrId_i;
    logic [31:0] DE_rs1_i;
    logic [31:0] DE_rs2_i;
    logic [31:0] DE_imm_i;
    logic [2:0]  DE_funct3_i;
    logic        DE_funct7b5_i;
    logic        DE_wbEnable_i;

    logic        E_stall_o;

    logic [31:0] EM_PC_o;
    logic [31:0] EM_instr_o;
    logic [31:0] EM_rs2_o;
    logic [31:0] EM_Eresult_o;
    logic [31:0] EM_addr_o;
    logic [31:0] EM_PCcorrection_o;
    logic        EM_nop_o;
    logic        EM_isLoad_o;
    logic        EM_isStore_o;
    logic        EM_isCSR_o;
    logic        EM_correctPC_o;
    logic        EM_wbEnable_o;
    logic [4:0]  EM_rdId_o;
    logic [4:0]  EM_rs1Id_o;
    logic [4:0]  EM_rs2Id_o;
    logic [11:0] EM_csrId_o;
    logic [2:0]  EM_funct3_o;

    modport slave (
        input  DE_PC_i, DE_instr_i, DE_nop_i, DE_isALUreg_i, DE_isALUimm_i, DE_isBranch_i,
               DE_isJAL_i, DE_isJALR_i, DE_isLUI_i, DE_isAUIPC_i, DE_isLoad_i, DE_isStore_i,
               DE_isCSR_i, DE_isMulDiv_i, DE_rdId_i, DE_rs1Id_i, DE_rs2Id_i, DE_csrId_i,
               DE_rs1_i, DE_rs2_i, DE_imm_i, DE_funct3_i, DE_funct7b5_i, DE_wbEnable_i,
        output E_stall_o,
        output EM_PC_o, EM_instr_o, EM_rs2_o, EM_Eresult_o, EM_addr_o, EM_PCcorrection_o,
               EM_nop_o, EM_isLoad_o, EM_isStore_o, EM_isCSR_o, EM_correctPC_o, EM_wbEnable_o,
               EM_rdId_o, EM_rs1Id_o, EM_rs2Id_o, EM_csrId_o, EM_funct3_o
    );

    modport master (
        output DE_PC_i, DE_instr_i, DE_nop_i, DE_isALUreg_i, DE_isALUimm_i, DE_isBranch_i,
               DE_isJAL_i, DE_isJALR_i, DE_isLUI_i, DE_isAUIPC_i, DE_isLoad_i, DE_isStore_i,
               DE_isCSR_i, DE_isMulDiv_i, DE_rdId_i, DE_rs1Id_i, DE_rs2Id_i, DE_csrId_i,
               DE_rs1_i, DE_rs2_i, DE_imm_i, DE_funct3_i, DE_funct7b5_i, DE_wbEnable_i,
        input  E_stall_o,
        input  EM_PC_o, EM_instr_o, EM_rs2_o, EM_Eresult_o, EM_addr_o, EM_PCcorrection_o,
               EM_nop_o, EM_isLoad_o, EM_isStore_o, EM_isCSR_o, EM_correctPC_o, EM_wbEnable_o,
               EM_rdId_o, EM_rs1Id_o, EM_rs2Id_o, EM_csrId_o, EM_funct3_o
    );
endinterface

// File: rtl/riscv_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: works on magnitudes and
// sign-corrects in DONE; divide-by-zero skips the iteration phase entirely.
module riscv_divider
    import rv_pkg::*;
#(
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [4:0]  rd_id,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  result_rd_id
);

    localparam int         ITERS      = XLEN / DIV_BITS_PER_CYCLE;
    localparam logic [5:0] LAST_COUNT = 6'(ITERS - 1);

    div_state_t  state_r, state_next_s;
    logic [5:0]  count_r;
    logic [31:0] quo_r, rem_r, dsr_r, dividend_r;
    logic        neg_q_r, neg_r_r, is_rem_r, div_zero_r;
    logic [4:0]  rd_r;

    logic        signed_s, a_neg_s, b_neg_s, div_zero_s;
    logic [63:0] step_s;
    logic [31:0] quo_fix_s, rem_fix_s;

    // op[0] selects unsigned, op[1] selects remainder
    assign signed_s   = ~op[0];
    assign a_neg_s    = signed_s & dividend[31];
    assign b_neg_s    = signed_s & divisor[31];
    assign div_zero_s = (divisor == 32'd0);

    function automatic logic [63:0] div_step(input logic [31:0] rem_in,
                                             input logic [31:0] quo_in,
                                             input logic [31:0] dsr);
        logic [31:0] r;
        logic [31:0] q;
        logic [32:0] shifted;
        logic [32:0] diff;
        r = rem_in;
        q = quo_in;
        for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
            shifted = {r, q[31]};
            diff    = shifted - {1'b0, dsr};
            if (!diff[32]) begin
                r = diff[31:0];
                q = {q[30:0], 1'b1};
            end else begin
                r = shifted[31:0];
                q = {q[30:0], 1'b0};
            end
        end
        return {r, q};
    endfunction

    assign step_s = div_step(rem_r, quo_r, dsr_r);

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (start) begin
                    state_next_s = div_zero_s ? DIV_DONE : DIV_BUSY;
                end else begin
                    state_next_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                if (count_r == 6'd0) begin
                    state_next_s = DIV_DONE;
                end else begin
                    state_next_s = DIV_BUSY;
                end
            end
            DIV_DONE: state_next_s = DIV_IDLE;
            default:  state_next_s = DIV_IDLE;
        endcase
    end

    // Operand capture at start and one restoring step per BUSY cycle
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r    <= 6'd0;
            quo_r      <= 32'd0;
            rem_r      <= 32'd0;
            dsr_r      <= 32'd0;
            dividend_r <= 32'd0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            is_rem_r   <= 1'b0;
            div_zero_r <= 1'b0;
            rd_r       <= 5'd0;
        end else if ((state_r == DIV_IDLE) && start) begin
            count_r    <= LAST_COUNT;
            quo_r      <= negate_if(a_neg_s, dividend);
            rem_r      <= 32'd0;
            dsr_r      <= negate_if(b_neg_s, divisor);
            dividend_r <= dividend;
            neg_q_r    <= a_neg_s ^ b_neg_s;
            neg_r_r    <= a_neg_s;
            is_rem_r   <= op[1];
            div_zero_r <= div_zero_s;
            rd_r       <= rd_id;
        end else if (state_r == DIV_BUSY) begin
            rem_r   <= step_s[63:32];
            quo_r   <= step_s[31:0];
            count_r <= count_r - 6'd1;
        end
    end

    // Handshake flags and sign-corrected result
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        result_rd_id = rd_r;
        case (state_r)
            DIV_BUSY: busy = 1'b1;
            DIV_DONE: done = 1'b1;
            default:  busy = 1'b0;
        endcase
        if (div_zero_r) begin
            quo_fix_s = 32'hFFFF_FFFF;
            rem_fix_s = dividend_r;
        end else begin
            quo_fix_s = negate_if(neg_q_r, quo_r);
            rem_fix_s = negate_if(neg_r_r, rem_r);
        end
        result = is_rem_r ? rem_fix_s : quo_fix_s;
    end

endmodule

// File: rtl/execute_unit.sv
// RV32IM execute stage: ALU, multiplier, branch resolution and address
// generation in one cycle; DIV/REM via the iterative divider with a Decode stall.
module execute_unit
    import rv_pkg::*;
#(
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    execute_unit_if.slave bus
);

    em_t         em_r, em_next_s;
    logic        kill_s, valid_s, is_div_s, div_start_s, div_busy_s, div_done_s;
    logic [31:0] div_result_s;
    logic [4:0]  div_rd_s;
    logic [31:0] alu_b_s, alu_s;
    logic [4:0]  shamt_s;
    logic        mul_a_sext_s, mul_b_sext_s;
    logic [63:0] mul_a_s, mul_b_s, mul_p_s;
    logic [31:0] mul_s;
    logic        taken_s, redirect_s;
    logic [31:0] pc_plus4_s, pc_imm_s, addr_s, target_s, eresult_s;

    // A redirect in EM kills whatever Decode presents this cycle
    assign kill_s      = bus.DE_nop_i | em_r.correct_pc;
    assign valid_s     = ~kill_s;
    assign is_div_s    = valid_s & bus.DE_isMulDiv_i & bus.DE_funct3_i[2];
    assign div_start_s = is_div_s & ~div_busy_s & ~div_done_s & ~reset_i;

    riscv_divider #(
        .DIV_BITS_PER_CYCLE(DIV_BITS_PER_CYCLE)
    ) u_divider (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start        (div_start_s),
        .op           (bus.DE_funct3_i[1:0]),
        .dividend     (bus.DE_rs1_i),
        .divisor      (bus.DE_rs2_i),
        .rd_id        (bus.DE_rdId_i),
        .busy         (div_busy_s),
        .done         (div_done_s),
        .result       (div_result_s),
        .result_rd_id (div_rd_s)
    );

    assign alu_b_s    = bus.DE_isALUreg_i ? bus.DE_rs2_i : bus.DE_imm_i;
    assign shamt_s    = alu_b_s[4:0];
    assign pc_plus4_s = bus.DE_PC_i + 32'd4;
    assign pc_imm_s   = bus.DE_PC_i + bus.DE_imm_i;
    assign addr_s     = bus.DE_rs1_i + bus.DE_imm_i;
    assign target_s   = bus.DE_isJALR_i ? {addr_s[31:1], 1'b0} : pc_imm_s;

    // Integer ALU
    always_comb begin
        alu_s = 32'd0;
        case (bus.DE_funct3_i)
            F3_ADD:  alu_s = (bus.DE_isALUreg_i & bus.DE_funct7b5_i) ? (bus.DE_rs1_i - alu_b_s)
                                                                     : (bus.DE_rs1_i + alu_b_s);
            F3_SLL:  alu_s = bus.DE_rs1_i << shamt_s;
            F3_SLT:  alu_s = {31'd0, $signed(bus.DE_rs1_i) < $signed(alu_b_s)};
            F3_SLTU: alu_s = {31'd0, bus.DE_rs1_i < alu_b_s};
            F3_XOR:  alu_s = bus.DE_rs1_i ^ alu_b_s;
            F3_SR:   alu_s = bus.DE_funct7b5_i ? 32'($signed(bus.DE_rs1_i) >>> shamt_s)
                                               : (bus.DE_rs1_i >> shamt_s);
            F3_OR:   alu_s = bus.DE_rs1_i | alu_b_s;
            F3_AND:  alu_s = bus.DE_rs1_i & alu_b_s;
            default: alu_s = 32'd0;
        endcase
    end

    // Operands sign- or zero-extended to 64 bits; the low 64 product bits
    // equal the 33x33 signed product for every MUL flavour.
    assign mul_a_sext_s = ((bus.DE_funct3_i == F3_MULH) || (bus.DE_funct3_i == F3_MULHSU))
                          & bus.DE_rs1_i[31];
    assign mul_b_sext_s = (bus.DE_funct3_i == F3_MULH) & bus.DE_rs2_i[31];
    assign mul_a_s      = {{32{mul_a_sext_s}}, bus.DE_rs1_i};
    assign mul_b_s      = {{32{mul_b_sext_s}}, bus.DE_rs2_i};
    assign mul_p_s      = mul_a_s * mul_b_s;
    assign mul_s        = (bus.DE_funct3_i == F3_MUL) ? mul_p_s[31:0] : mul_p_s[63:32];

    // Branch condition
    always_comb begin
        taken_s = 1'b0;
        case (bus.DE_funct3_i)
            F3_BEQ:  taken_s = (bus.DE_rs1_i == bus.DE_rs2_i);
            F3_BNE:  taken_s = (bus.DE_rs1_i != bus.DE_rs2_i);
            F3_BLT:  taken_s = ($signed(bus.DE_rs1_i) < $signed(bus.DE_rs2_i));
            F3_BGE:  taken_s = ($signed(bus.DE_rs1_i) >= $signed(bus.DE_rs2_i));
            F3_BLTU: taken_s = (bus.DE_rs1_i < bus.DE_rs2_i);
            F3_BGEU: taken_s = (bus.DE_rs1_i >= bus.DE_rs2_i);
            default: taken_s = 1'b0;
        endcase
    end

    assign redirect_s = valid_s & (bus.DE_isJAL_i | bus.DE_isJALR_i | (bus.DE_isBranch_i & taken_s));

    // Result select for single-cycle ops
    always_comb begin
        eresult_s = 32'd0;
        if (bus.DE_isJAL_i | bus.DE_isJALR_i) begin
            eresult_s = pc_plus4_s;
        end else if (bus.DE_isLUI_i) begin
            eresult_s = bus.DE_imm_i;
        end else if (bus.DE_isAUIPC_i) begin
            eresult_s = pc_imm_s;
        end else if (bus.DE_isMulDiv_i) begin
            eresult_s = mul_s;
        end else if (bus.DE_isALUreg_i | bus.DE_isALUimm_i) begin
            eresult_s = alu_s;
        end else begin
            eresult_s = 32'd0;
        end
    end

    // Next EX/MEM contents: divider result, bubble while dividing, or the current op
    always_comb begin
        em_next_s = EM_BUBBLE;
        if (div_done_s) begin
            em_next_s.pc        = bus.DE_PC_i;
            em_next_s.instr     = bus.DE_instr_i;
            em_next_s.rs2       = bus.DE_rs2_i;
            em_next_s.eresult   = div_result_s;
            em_next_s.nop       = 1'b0;
            em_next_s.wb_enable = bus.DE_wbEnable_i;
            em_next_s.rd_id     = div_rd_s;
            em_next_s.rs1_id    = bus.DE_rs1Id_i;
            em_next_s.rs2_id    = bus.DE_rs2Id_i;
            em_next_s.funct3    = bus.DE_funct3_i;
        end else if (div_start_s | div_busy_s) begin
            em_next_s = EM_BUBBLE;
        end else begin
            em_next_s.pc            = bus.DE_PC_i;
            em_next_s.instr         = bus.DE_instr_i;
            em_next_s.rs2           = bus.DE_rs2_i;
            em_next_s.eresult       = eresult_s;
            em_next_s.addr          = addr_s;
            em_next_s.pc_correction = target_s;
            em_next_s.nop           = kill_s;
            em_next_s.is_load       = valid_s & bus.DE_isLoad_i;
            em_next_s.is_store      = valid_s & bus.DE_isStore_i;
            em_next_s.is_csr        = valid_s & bus.DE_isCSR_i;
            em_next_s.correct_pc    = redirect_s;
            em_next_s.wb_enable     = valid_s & bus.DE_wbEnable_i;
            em_next_s.rd_id         = bus.DE_rdId_i;
            em_next_s.rs1_id        = bus.DE_rs1Id_i;
            em_next_s.rs2_id        = bus.DE_rs2Id_i;
            em_next_s.csr_id        = bus.DE_csrId_i;
            em_next_s.funct3        = bus.DE_funct3_i;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            em_r <= EM_BUBBLE;
        end else begin
            em_r <= em_next_s;
        end
    end

    assign bus.E_stall_o         = div_start_s | div_busy_s;
    assign bus.EM_PC_o           = em_r.pc;
    assign bus.EM_instr_o        = em_r.instr;
    assign bus.EM_rs2_o          = em_r.rs2;
    assign bus.EM_Eresult_o      = em_r.eresult;
    assign bus.EM_addr_o         = em_r.addr;
    assign bus.EM_PCcorrection_o = em_r.pc_correction;
    assign bus.EM_nop_o          = em_r.nop;
    assign bus.EM_isLoad_o       = em_r.is_load;
    assign bus.EM_isStore_o      = em_r.is_store;
    assign bus.EM_isCSR_o        = em_r.is_csr;
    assign bus.EM_correctPC_o    = em_r.correct_pc;
    assign bus.EM_wbEnable_o     = em_r.wb_enable;
    assign bus.EM_rdId_o         = em_r.rd_id;
    assign bus.EM_rs1Id_o        = em_r.rs1_id;
    assign bus.EM_rs2Id_o        = em_r.rs2_id;
    assign bus.EM_csrId_o        = em_r.csr_id;
    assign bus.EM_funct3_o       = em_r.funct3;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: single-cycle ops, redirects and squash,
// multiplier, divider latency/sign rules and reset during a division.
module tb_execute_unit;

    localparam int K_NOP    = 0;
    localparam int K_ALUREG = 1;
    localparam int K_ALUIMM = 2;
    localparam int K_BRANCH = 3;
    localparam int K_JAL    = 4;
    localparam int K_JALR   = 5;
    localparam int K_LUI    = 6;
    localparam int K_AUIPC  = 7;
    localparam int K_LOAD   = 8;
    localparam int K_STORE  = 9;
    localparam int K_MULDIV = 10;

    logic clk_i;
    logic reset_i;
    int   n_checks;
    int   n_fails;

    execute_unit_if bus ();

    execute_unit #(.DIV_BITS_PER_CYCLE(1)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int kind, input logic [2:0] f3, input logic f7,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [4:0] rd);
        bus.DE_nop_i       = (kind == K_NOP);
        bus.DE_isALUreg_i  = (kind == K_ALUREG);
        bus.DE_isALUimm_i  = (kind == K_ALUIMM);
        bus.DE_isBranch_i  = (kind == K_BRANCH);
        bus.DE_isJAL_i     = (kind == K_JAL);
        bus.DE_isJALR_i    = (kind == K_JALR);
        bus.DE_isLUI_i     = (kind == K_LUI);
        bus.DE_isAUIPC_i   = (kind == K_AUIPC);
        bus.DE_isLoad_i    = (kind == K_LOAD);
        bus.DE_isStore_i   = (kind == K_STORE);
        bus.DE_isCSR_i     = 1'b0;
        bus.DE_isMulDiv_i  = (kind == K_MULDIV);
        bus.DE_PC_i        = pc;
        bus.DE_instr_i     = pc ^ 32'h0000_0013;
        bus.DE_rdId_i      = rd;
        bus.DE_rs1Id_i     = 5'd3;
        bus.DE_rs2Id_i     = 5'd4;
        bus.DE_csrId_i     = 12'h300;
        bus.DE_rs1_i       = rs1;
        bus.DE_rs2_i       = rs2;
        bus.DE_imm_i       = imm;
        bus.DE_funct3_i    = f3;
        bus.DE_funct7b5_i  = f7;
        bus.DE_wbEnable_i  = (rd != 5'd0) && (kind != K_NOP) && (kind != K_BRANCH) && (kind != K_STORE);
    endtask

    task automatic idle();
        drive(K_NOP, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    // Issue a DIV-class op, hold it while stalled, and check latency and result.
    task automatic run_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int bubble_err;
        lat = 0;
        bubble_err = 0;
        drive(K_MULDIV, f3, 1'b0, 32'h0000_0200, a, b, 32'd0, 5'd9);
        #1;
        check_eq({tag, "_stall_at_issue"}, 32'(bus.E_stall_o), 32'd1);
        while (bus.E_stall_o && (lat < 100)) begin
            tick();
            lat++;
            if (!bus.EM_nop_o) bubble_err++;
        end
        tick();
        lat++;
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_bubbles"}, 32'(bubble_err), 32'd0);
        check_eq({tag, "_nop"}, 32'(bus.EM_nop_o), 32'd0);
        check_eq({tag, "_result"}, bus.EM_Eresult_o, exp);
        check_eq({tag, "_rd"}, 32'(bus.EM_rdId_o), 32'd9);
        check_eq({tag, "_pc"}, bus.EM_PC_o, 32'h0000_0200);
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset_i  = 1'b1;
        idle();
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_nop", 32'(bus.EM_nop_o), 32'd1);
        check_eq("rst_correctpc", 32'(bus.EM_correctPC_o), 32'd0);
        check_eq("rst_wb", 32'(bus.EM_wbEnable_o), 32'd0);
        check_eq("rst_stall", 32'(bus.E_stall_o), 32'd0);
        check_eq("rst_eresult", bus.EM_Eresult_o, 32'd0);
        reset_i = 1'b0;
        tick();

        // ADDI x1,x0,-5 then SLTU x2,x1,x0
        drive(K_ALUIMM, 3'd0, 1'b0, 32'h0, 32'd0, 32'd0, 32'hFFFF_FFFB, 5'd1);
        #1;
        check_eq("addi_stall", 32'(bus.E_stall_o), 32'd0);
        tick();
        check_eq("addi_res", bus.EM_Eresult_o, 32'hFFFF_FFFB);
        check_eq("addi_nop", 32'(bus.EM_nop_o), 32'd0);
        check_eq("addi_wb", 32'(bus.EM_wbEnable_o), 32'd1);
        drive(K_ALUREG, 3'd3, 1'b0, 32'h4, 32'hFFFF_FFFB, 32'd0, 32'd0, 5'd2);
        tick();
        check_eq("sltu_res", bus.EM_Eresult_o, 32'd0);
        check_eq("sltu_nop", 32'(bus.EM_nop_o), 32'd0);

        drive(K_ALUREG, 3'd0, 1'b1, 32'h8, 32'd10, 32'd3, 32'd0, 5'd5);
        tick();
        check_eq("sub_res", bus.EM_Eresult_o, 32'd7);
        drive(K_ALUIMM, 3'd5, 1'b1, 32'hC, 32'h8000_0000, 32'd0, 32'h0000_0404, 5'd5);
        tick();
        check_eq("srai_res", bus.EM_Eresult_o, 32'hF800_0000);
        drive(K_AUIPC, 3'd0, 1'b0, 32'h1000, 32'd0, 32'd0, 32'h2000, 5'd6);
        tick();
        check_eq("auipc_res", bus.EM_Eresult_o, 32'h3000);
        drive(K_LUI, 3'd0, 1'b0, 32'h1004, 32'd0, 32'd0, 32'hABCD_E000, 5'd6);
        tick();
        check_eq("lui_res", bus.EM_Eresult_o, 32'hABCD_E000);

        drive(K_STORE, 3'd2, 1'b0, 32'h1008, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 32'h20, 5'd0);
        tick();
        check_eq("st_addr", bus.EM_addr_o, 32'h10);
        check_eq("st_rs2", bus.EM_rs2_o, 32'hDEAD_BEEF);
        check_eq("st_isstore", 32'(bus.EM_isStore_o), 32'd1);
        check_eq("st_wb", 32'(bus.EM_wbEnable_o), 32'd0);

        // Taken BEQ, then the following op must be squashed
        drive(K_BRANCH, 3'd0, 1'b0, 32'h100, 32'd5, 32'd5, 32'h20, 5'd0);
        tick();
        check_eq("beq_correct", 32'(bus.EM_correctPC_o), 32'd1);
        check_eq("beq_target", bus.EM_PCcorrection_o, 32'h120);
        drive(K_ALUIMM, 3'd0, 1'b0, 32'h104, 32'd1, 32'd0, 32'd1, 5'd1);
        tick();
        check_eq("squash_nop", 32'(bus.EM_nop_o), 32'd1);
        check_eq("squash_wb", 32'(bus.EM_wbEnable_o), 32'd0);
        check_eq("squash_correct", 32'(bus.EM_correctPC_o), 32'd0);

        drive(K_BRANCH, 3'd1, 1'b0, 32'h120, 32'd5, 32'd5, 32'h40, 5'd0);
        tick();
        check_eq("bne_nt_correct", 32'(bus.EM_correctPC_o), 32'd0);
        check_eq("bne_nt_nop", 32'(bus.EM_nop_o), 32'd0);
        drive(K_BRANCH, 3'd6, 1'b0, 32'h124, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 5'd0);
        tick();
        check_eq("bltu_correct", 32'(bus.EM_correctPC_o), 32'd1);
        check_eq("bltu_target", bus.EM_PCcorrection_o, 32'h114);
        drive(K_BRANCH, 3'd4, 1'b0, 32'h114, 32'd1, 32'hFFFF_FFFF, 32'h8, 5'd0);
        tick();
        check_eq("blt_squashed", 32'(bus.EM_nop_o), 32'd1);
        tick();
        check_eq("blt_nt_correct", 32'(bus.EM_correctPC_o), 32'd0);

        drive(K_JALR, 3'd0, 1'b0, 32'h40, 32'h203, 32'd0, 32'd0, 5'd1);
        tick();
        check_eq("jalr_res", bus.EM_Eresult_o, 32'h44);
        check_eq("jalr_target", bus.EM_PCcorrection_o, 32'h202);
        check_eq("jalr_correct", 32'(bus.EM_correctPC_o), 32'd1);
        idle();
        tick();

        drive(K_MULDIV, 3'd1, 1'b0, 32'h300, 32'h8000_0000, 32'h8000_0000, 32'd0, 5'd7);
        tick();
        check_eq("mulh_res", bus.EM_Eresult_o, 32'h4000_0000);
        check_eq("mulh_stall", 32'(bus.E_stall_o), 32'd0);
        drive(K_MULDIV, 3'd3, 1'b0, 32'h304, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd7);
        tick();
        check_eq("mulhu_res", bus.EM_Eresult_o, 32'hFFFF_FFFE);
        drive(K_MULDIV, 3'd0, 1'b0, 32'h308, 32'd7, 32'hFFFF_FFFD, 32'd0, 5'd7);
        tick();
        check_eq("mul_res", bus.EM_Eresult_o, 32'hFFFF_FFEB);
        drive(K_MULDIV, 3'd2, 1'b0, 32'h30C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd7);
        tick();
        check_eq("mulhsu_res", bus.EM_Eresult_o, 32'hFFFF_FFFF);
        idle();
        tick();

        run_div("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_div("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_div("div_by0", 3'd4, 32'd1234, 32'd0, 32'hFFFF_FFFF, 2);
        run_div("rem_by0", 3'd6, 32'd1234, 32'd0, 32'd1234, 2);
        run_div("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run_div("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

        // Reset in the middle of a DIVU, then a fresh DIVU
        drive(K_MULDIV, 3'd5, 1'b0, 32'h400, 32'h0000_FFFF, 32'd3, 32'd0, 5'd9);
        repeat (10) tick();
        check_eq("mid_div_stall", 32'(bus.E_stall_o), 32'd1);
        reset_i = 1'b1;
        #1;
        check_eq("rst_mid_stall", 32'(bus.E_stall_o), 32'd0);
        check_eq("rst_mid_nop", 32'(bus.EM_nop_o), 32'd1);
        tick();
        reset_i = 1'b0;
        run_div("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
